// File: rtl/apb_param_stager.sv
// APB slave staging per-slave timer parameter words in shadow registers;
// a CTRL commit pulses en_o so the parameter bank loads all words at once.
module apb_param_stager #(
  parameter int               WIDTH       = 32,
  parameter int               NUM_SLAVE   = 8,
  parameter int               ADDR_W      = 8,
  parameter int               WAIT_CYCLES = 0,
  parameter logic [WIDTH-1:0] RESET_VAL   = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         psel,
  input  logic                         penable,
  input  logic                         pwrite,
  input  logic [ADDR_W-1:0]            paddr,
  input  logic [31:0]                  pwdata,
  input  logic [3:0]                   pstrb,
  output logic [31:0]                  prdata,
  output logic                         pready,
  output logic                         pslverr,
  output logic [NUM_SLAVE*WIDTH-1:0]   d_o,
  output logic                         en_o,
  input  logic [NUM_SLAVE*WIDTH-1:0]   q_i
);

  // state  | meaning
  // IDLE   | no transfer in progress, waiting for a setup phase
  // ACCESS | transfer decoded, counting wait states until pready

  localparam int         NUM_BYTES = WIDTH / 8;
  localparam logic [2:0] WAIT_LAST = 3'(WAIT_CYCLES);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t           state;
  logic [2:0]       wait_cnt;
  logic [WIDTH-1:0] shadow [NUM_SLAVE];
  logic             dirty;
  logic [7:0]       commit_cnt;

  logic [7:0]  addr_lo;
  logic [3:0]  idx;
  logic        hi_zero;
  logic        idx_ok;
  logic        is_shadow;
  logic        is_live;
  logic        is_ctrl;
  logic        is_status;
  logic        err;
  logic [31:0] rd_val;
  logic [31:0] resp_data;
  logic        do_commit;

  // Address decode; every bit above the 8-bit map must be zero to hit a register
  always_comb begin
    addr_lo   = paddr[7:0];
    idx       = addr_lo[5:2];
    hi_zero   = ((paddr >> 8) == '0);
    idx_ok    = (int'(idx) < NUM_SLAVE);
    is_shadow = hi_zero && (addr_lo[7:6] == 2'b00);
    is_live   = hi_zero && (addr_lo[7:6] == 2'b01);
    is_ctrl   = hi_zero && (addr_lo == 8'h80);
    is_status = hi_zero && (addr_lo == 8'h84);
    err = (addr_lo[1:0] != 2'b00)
        || ((is_shadow || is_live) && !idx_ok)
        || !(is_shadow || is_live || is_ctrl || is_status)
        || (pwrite && (is_live || is_status))
        || (!pwrite && is_ctrl);
  end

  always_comb begin
    rd_val = 32'h0;
    for (int i = 0; i < NUM_SLAVE; i++) begin
      if (is_shadow && int'(idx) == i) rd_val = 32'(shadow[i]);
      if (is_live && int'(idx) == i)   rd_val = 32'(q_i[i*WIDTH +: WIDTH]);
    end
    if (is_status) rd_val = {16'h0, commit_cnt, 7'h0, dirty};
    resp_data = (!pwrite && !err) ? rd_val : 32'h0;
    do_commit = pwrite && !err && is_ctrl && pwdata[0] && pstrb[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wait_cnt   <= 3'd0;
      prdata     <= 32'h0;
      pready     <= 1'b0;
      pslverr    <= 1'b0;
      en_o       <= 1'b0;
      dirty      <= 1'b0;
      commit_cnt <= 8'h0;
      for (int i = 0; i < NUM_SLAVE; i++) shadow[i] <= RESET_VAL;
    end else begin
      en_o <= 1'b0;
      case (state)
        IDLE: begin
          pready  <= 1'b0;
          pslverr <= 1'b0;
          prdata  <= 32'h0;
          if (psel && !penable) begin
            state    <= ACCESS;
            wait_cnt <= 3'd0;
            if (WAIT_LAST == 3'd0) begin
              pready  <= 1'b1;
              pslverr <= err;
              prdata  <= resp_data;
            end
          end
        end
        ACCESS: begin
          if (!psel) begin
            // Abort: master withdrew the transfer, nothing is written
            state   <= IDLE;
            pready  <= 1'b0;
            pslverr <= 1'b0;
            prdata  <= 32'h0;
          end else if (pready) begin
            if (penable) begin
              state   <= IDLE;
              pready  <= 1'b0;
              pslverr <= 1'b0;
              prdata  <= 32'h0;
              if (pwrite && !err && is_shadow) begin
                dirty <= 1'b1;
                for (int i = 0; i < NUM_SLAVE; i++) begin
                  for (int b = 0; b < NUM_BYTES; b++) begin
                    if (int'(idx) == i && pstrb[b])
                      shadow[i][b*8 +: 8] <= pwdata[b*8 +: 8];
                  end
                end
              end
              if (do_commit) begin
                en_o       <= 1'b1;
                dirty      <= 1'b0;
                commit_cnt <= commit_cnt + 8'd1;
              end
            end
          end else begin
            wait_cnt <= wait_cnt + 3'd1;
            if ((wait_cnt + 3'd1) == WAIT_LAST) begin
              pready  <= 1'b1;
              pslverr <= err;
              prdata  <= resp_data;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_SLAVE; g++) begin : g_dout
    assign d_o[g*WIDTH +: WIDTH] = shadow[g];
  end

endmodule

// File: tb/tb_apb_param_stager.sv
// Directed bench: one zero-wait instance and one three-wait instance share the APB bus.
module tb_apb_param_stager;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         psel, penable, pwrite;
  logic [7:0]   paddr;
  logic [31:0]  pwdata;
  logic [3:0]   pstrb;
  logic         sel_w;

  logic [31:0]  prdata0, prdata1;
  logic         pready0, pready1, pslverr0, pslverr1, en0, en1;
  logic [255:0] d0, d1, q0, q1;
  logic         psel0, psel1;

  logic [31:0]  prdata_m;
  logic         pready_m, pslverr_m, en_m;
  logic [255:0] d_m;

  int total = 0;
  int bad   = 0;
  int en_cnt0 = 0;

  always #5 clk = ~clk;

  assign psel0     = psel & ~sel_w;
  assign psel1     = psel & sel_w;
  assign prdata_m  = sel_w ? prdata1 : prdata0;
  assign pready_m  = sel_w ? pready1 : pready0;
  assign pslverr_m = sel_w ? pslverr1 : pslverr0;
  assign en_m      = sel_w ? en1 : en0;
  assign d_m       = sel_w ? d1 : d0;

  apb_param_stager #(.WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .psel(psel0), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata0), .pready(pready0),
    .pslverr(pslverr0), .d_o(d0), .en_o(en0), .q_i(q0));

  apb_param_stager #(.WAIT_CYCLES(3), .RESET_VAL(32'h1234_5678)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .psel(psel1), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata1), .pready(pready1),
    .pslverr(pslverr1), .d_o(d1), .en_o(en1), .q_i(q1));

  always @(negedge clk) if (en0) en_cnt0++;

  initial begin
    for (int i = 0; i < 8; i++) begin
      q0[i*32 +: 32] = 32'hC0DE_0000 + 32'(i);
      q1[i*32 +: 32] = 32'hBEEF_0000 + 32'(i);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic apb(input bit w, input logic [7:0] a, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] rd, output logic er,
                     output int nacc, output logic en_seen, output logic [255:0] d_seen);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d; pstrb = s;
    @(posedge clk); #1;
    penable = 1'b1;
    nacc = 0; rd = 32'hx; er = 1'bx;
    forever begin
      nacc++;
      @(negedge clk);
      if (pready_m === 1'b1) begin
        rd = prdata_m; er = pslverr_m;
        break;
      end
      if (nacc > 20) begin
        total++; bad++;
        $display("FAIL timeout: pready not seen after %0d cycles at addr %02h", nacc, a);
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    en_seen = en_m; d_seen = d_m;
  endtask

  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [31:0]  rd;
    logic         er, en_seen;
    logic [255:0] ds;
    int           nacc, ec;

    vecs.push_back('{0, 8'h84, 32'h0, 4'h0, 32'h0000_0000, 1'b0});
    vecs.push_back('{0, 8'h80, 32'h0, 4'h0, 32'h0000_0000, 1'b1});
    vecs.push_back('{1, 8'h08, 32'hA5A5_0001, 4'b0011, 32'h0, 1'b0});
    vecs.push_back('{0, 8'h08, 32'h0, 4'h0, 32'h0000_0001, 1'b0});
    vecs.push_back('{0, 8'h84, 32'h0, 4'h0, 32'h0000_0001, 1'b0});
    vecs.push_back('{0, 8'h48, 32'h0, 4'h0, 32'hC0DE_0002, 1'b0});
    vecs.push_back('{1, 8'h20, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1});
    vecs.push_back('{1, 8'h40, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1});
    vecs.push_back('{0, 8'h81, 32'h0, 4'h0, 32'h0, 1'b1});
    vecs.push_back('{0, 8'h60, 32'h0, 4'h0, 32'h0, 1'b1});
    vecs.push_back('{0, 8'hC0, 32'h0, 4'h0, 32'h0, 1'b1});
    vecs.push_back('{1, 8'h84, 32'h0000_0001, 4'hF, 32'h0, 1'b1});
    vecs.push_back('{0, 8'h84, 32'h0, 4'h0, 32'h0000_0001, 1'b0});
    vecs.push_back('{1, 8'h0C, 32'h1122_3344, 4'b0000, 32'h0, 1'b0});
    vecs.push_back('{0, 8'h0C, 32'h0, 4'h0, 32'h0000_0000, 1'b0});
    vecs.push_back('{1, 8'h0C, 32'h1122_3344, 4'b1010, 32'h0, 1'b0});
    vecs.push_back('{0, 8'h0C, 32'h0, 4'h0, 32'h1100_3300, 1'b0});
    vecs.push_back('{0, 8'h1C, 32'h0, 4'h0, 32'h0000_0000, 1'b0});

    psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0; pstrb = 0; sel_w = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_pready", {31'h0, pready0}, 32'h0);
    chk("reset_en", {31'h0, en0}, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      apb(0, 8'(4*i), 32'h0, 4'h0, rd, er, nacc, en_seen, ds);
      chk($sformatf("reset_shadow%0d", i), rd, 32'h0);
    end

    for (int i = 0; i < vecs.size(); i++) begin
      apb(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, rd, er, nacc, en_seen, ds);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      chk($sformatf("vec%0d_err", i), {31'h0, er}, {31'h0, vecs[i].exp_err});
    end
    chk("no_en_before_commit", 32'(en_cnt0), 32'd0);

    // commit with dirty set
    ec = en_cnt0;
    apb(1, 8'h80, 32'h1, 4'h1, rd, er, nacc, en_seen, ds);
    chk("commit_en_high", {31'h0, en_seen}, 32'h1);
    chk("commit_d2", ds[2*32 +: 32], 32'h0000_0001);
    @(posedge clk); #1;
    chk("commit_en_low", {31'h0, en0}, 32'h0);
    chk("commit_en_pulses", 32'(en_cnt0 - ec), 32'd1);
    apb(0, 8'h84, 32'h0, 4'h0, rd, er, nacc, en_seen, ds);
    chk("status_after_commit", rd, 32'h0000_0100);

    // commit with dirty clear still pulses
    ec = en_cnt0;
    apb(1, 8'h80, 32'h1, 4'h1, rd, er, nacc, en_seen, ds);
    chk("clean_commit_en", {31'h0, en_seen}, 32'h1);
    apb(1, 8'h80, 32'h1, 4'h0, rd, er, nacc, en_seen, ds);
    chk("ctrl_nostrb_err", {31'h0, er}, 32'h0);
    apb(1, 8'h80, 32'h0, 4'h1, rd, er, nacc, en_seen, ds);
    chk("ctrl_bit0_zero_en", {31'h0, en_seen}, 32'h0);
    chk("commit_pulse_count", 32'(en_cnt0 - ec), 32'd1);
    apb(0, 8'h84, 32'h0, 4'h0, rd, er, nacc, en_seen, ds);
    chk("status_two_commits", rd, 32'h0000_0200);
    chk("d_word3", d0[3*32 +: 32], 32'h1100_3300);

    // wait-state instance
    sel_w = 1'b1;
    apb(0, 8'h00, 32'h0, 4'h0, rd, er, nacc, en_seen, ds);
    chk("wait_nacc", 32'(nacc), 32'd4);
    chk("wait_reset_val", rd, 32'h1234_5678);

    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h08; pwdata = 32'hFFFF_FFFF; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    chk("abort_pready_low", {31'h0, pready1}, 32'h0);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    repeat (2) @(posedge clk);
    apb(0, 8'h08, 32'h0, 4'h0, rd, er, nacc, en_seen, ds);
    chk("abort_no_write", rd, 32'h1234_5678);
    apb(0, 8'h84, 32'h0, 4'h0, rd, er, nacc, en_seen, ds);
    chk("abort_not_dirty", rd, 32'h0);

    apb(1, 8'h04, 32'hDEAD_BEEF, 4'hF, rd, er, nacc, en_seen, ds);
    chk("wait_write_nacc", 32'(nacc), 32'd4);
    apb(0, 8'h04, 32'h0, 4'h0, rd, er, nacc, en_seen, ds);
    chk("wait_readback", rd, 32'hDEAD_BEEF);
    apb(0, 8'h44, 32'h0, 4'h0, rd, er, nacc, en_seen, ds);
    chk("wait_live1", rd, 32'hBEEF_0001);

    // reset mid-access on the wait-state instance
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h04;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_pready", {31'h0, pready1}, 32'h0);
    chk("rst_mid_shadow", d1[1*32 +: 32], 32'h1234_5678);
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // reset during the en_o cycle
    sel_w = 1'b0;
    apb(1, 8'h00, 32'h0000_00AB, 4'hF, rd, er, nacc, en_seen, ds);
    apb(1, 8'h80, 32'h1, 4'h1, rd, er, nacc, en_seen, ds);
    chk("pre_rst_en", {31'h0, en_seen}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rst_en_dropped", {31'h0, en0}, 32'h0);
    chk("rst_pready", {31'h0, pready0}, 32'h0);
    chk("rst_shadow0", d0[31:0], 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    apb(0, 8'h84, 32'h0, 4'h0, rd, er, nacc, en_seen, ds);
    chk("rst_status", rd, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
